// File: rtl/move_history_stack_if.sv
// Push / undo / board-write bundle shared by the move executor, the history stack and the board store.
// The executor side uses the master modport; the history stack uses the slave modport.
interface move_history_stack_if #(
  parameter int SQ_W    = 6,
  parameter int PIECE_W = 4,
  parameter int DEPTH   = 16
) ();
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic               push_valid;
  logic               push_ready;
  logic [SQ_W-1:0]    push_from;
  logic [SQ_W-1:0]    push_to;
  logic [PIECE_W-1:0] push_moved;
  logic [PIECE_W-1:0] push_captured;
  logic               undo_req;
  logic               undo_ready;
  logic               undo_done;
  logic               clear;
  logic               bw_en;
  logic [SQ_W-1:0]    bw_addr;
  logic [PIECE_W-1:0] bw_data;
  logic [CNT_W-1:0]   count;
  logic               empty;
  logic               full;
  logic               overflow_err;
  logic               underflow_err;

  modport master (
    output push_valid, push_from, push_to, push_moved, push_captured, undo_req, clear,
    input  push_ready, undo_ready, undo_done, bw_en, bw_addr, bw_data, count, empty, full,
           overflow_err, underflow_err
  );

  modport slave (
    input  push_valid, push_from, push_to, push_moved, push_captured, undo_req, clear,
    output push_ready, undo_ready, undo_done, bw_en, bw_addr, bw_data, count, empty, full,
           overflow_err, underflow_err
  );
endinterface

// File: rtl/move_history_stack.sv
// LIFO of executed chess moves held in a circular buffer, with a three-state undo engine
// that restores the moved piece and then the captured piece through the board write port.
module move_history_stack #(
  parameter int SQ_W      = 6,
  parameter int PIECE_W   = 4,
  parameter int DEPTH     = 16,
  parameter int OVERWRITE = 0
) (
  input  logic clk,
  input  logic rst_n,
  move_history_stack_if.slave bus
);
  localparam int REC_W = 2 * SQ_W + 2 * PIECE_W;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W:0]   DEPTH_X  = (CNT_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, WR_FROM, WR_TO} state_e;

  state_e             state_q;
  logic [REC_W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]   base_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [SQ_W-1:0]    undoTo_q;
  logic [PIECE_W-1:0] undoCap_q;
  logic               bwEn_q;
  logic [SQ_W-1:0]    bwAddr_q;
  logic [PIECE_W-1:0] bwData_q;
  logic               done_q;
  logic               ovf_q;
  logic               unf_q;

  // Sum never exceeds 2*DEPTH-1, so one conditional subtract wraps correctly for any DEPTH.
  function automatic logic [PTR_W-1:0] wrapAdd(input logic [PTR_W-1:0] p,
                                               input logic [CNT_W-1:0] off);
    logic [CNT_W:0] s;
    s = (CNT_W + 1)'(p) + (CNT_W + 1)'(off);
    if (s >= DEPTH_X) s = s - DEPTH_X;
    return PTR_W'(s);
  endfunction

  logic             fullNow;
  logic             idleFree;
  logic             pushReady;
  logic             pushFire;
  logic             pushDrop;
  logic             undoFire;
  logic             undoUnder;
  logic [CNT_W-1:0] topOff;
  logic [PTR_W-1:0] topIdx;
  logic [PTR_W-1:0] wrIdx;
  logic [REC_W-1:0] topRec;

  assign fullNow   = (cnt_q == FULL_CNT);
  assign idleFree  = (state_q == IDLE) && !bus.clear;
  assign pushReady = idleFree && !bus.undo_req && (!fullNow || (OVERWRITE != 0));
  assign pushFire  = bus.push_valid && pushReady;
  assign pushDrop  = idleFree && !bus.undo_req && bus.push_valid && fullNow && (OVERWRITE == 0);
  assign undoFire  = idleFree && bus.undo_req && (cnt_q != '0);
  assign undoUnder = idleFree && bus.undo_req && (cnt_q == '0);

  // When full in ring mode the write slot equals the oldest slot, so one formula covers both cases.
  assign topOff = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
  assign topIdx = wrapAdd(base_q, topOff);
  assign wrIdx  = wrapAdd(base_q, cnt_q);
  assign topRec = mem_q[topIdx];

  always_ff @(posedge clk) begin
    if (pushFire) begin
      mem_q[wrIdx] <= {bus.push_from, bus.push_to, bus.push_moved, bus.push_captured};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      base_q    <= '0;
      cnt_q     <= '0;
      undoTo_q  <= '0;
      undoCap_q <= '0;
      bwEn_q    <= 1'b0;
      bwAddr_q  <= '0;
      bwData_q  <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      bwEn_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      if (bus.clear) begin
        state_q <= IDLE;
        base_q  <= '0;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (undoFire) begin
              cnt_q     <= cnt_q - 1'b1;
              undoTo_q  <= topRec[2*PIECE_W +: SQ_W];
              undoCap_q <= topRec[PIECE_W-1:0];
              bwEn_q    <= 1'b1;
              bwAddr_q  <= topRec[REC_W-1 -: SQ_W];
              bwData_q  <= topRec[PIECE_W +: PIECE_W];
              state_q   <= WR_FROM;
            end else if (undoUnder) begin
              unf_q <= 1'b1;
            end else if (pushFire) begin
              if (fullNow) base_q <= wrapAdd(base_q, CNT_W'(1));
              else         cnt_q  <= cnt_q + 1'b1;
            end else if (pushDrop) begin
              ovf_q <= 1'b1;
            end
          end
          WR_FROM: begin
            bwEn_q   <= 1'b1;
            bwAddr_q <= undoTo_q;
            bwData_q <= undoCap_q;
            done_q   <= 1'b1;
            state_q  <= WR_TO;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.push_ready    = pushReady;
  assign bus.undo_ready    = (state_q == IDLE);
  assign bus.undo_done     = done_q;
  assign bus.bw_en         = bwEn_q;
  assign bus.bw_addr       = bwAddr_q;
  assign bus.bw_data       = bwData_q;
  assign bus.count         = cnt_q;
  assign bus.empty         = (cnt_q == '0);
  assign bus.full          = fullNow;
  assign bus.overflow_err  = ovf_q;
  assign bus.underflow_err = unf_q;
endmodule
